// File: rtl/dmem_ctrl_if.sv
// Requester bus and dcache port of the data-memory controller.
// slave = controller side, master = requesters plus dcache side.
interface dmem_ctrl_if #(
    parameter int NPORTS = 2
);
    logic [NPORTS-1:0]        req_valid;
    logic [NPORTS-1:0]        req_ready;
    logic [NPORTS-1:0]        req_we;
    logic [NPORTS-1:0][31:0]  req_addr;
    logic [NPORTS-1:0][31:0]  req_wdata;
    logic [NPORTS-1:0][3:0]   req_wstrb;
    logic [NPORTS-1:0]        resp_valid;
    logic [31:0]              resp_rdata;
    logic                     busy;
    logic                     r_enable;
    logic [31:0]              r_addr;
    logic [31:0]              r_data;
    logic                     w_enable;
    logic [31:0]              w_addr;
    logic [31:0]              w_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, r_data,
        output req_ready, resp_valid, resp_rdata, busy,
               r_enable, r_addr, w_enable, w_addr, w_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, r_data,
        input  req_ready, resp_valid, resp_rdata, busy,
               r_enable, r_addr, w_enable, w_addr, w_data
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Shares the single dcache port among NPORTS requesters; sub-word stores are read-modify-write.
// Define DMEM_CTRL_RR_EN for round-robin arbitration (default: lowest index wins).
module dmem_ctrl #(
    parameter int NPORTS = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int IW = (NPORTS > 2) ? 2 : 1;

    // state | meaning
    // IDLE  | waiting for a request; grant happens here
    // READ  | dcache read of the target word into rbuf
    // WRITE | dcache write of the (merged) word
    // RESP  | response pulse to the granted port
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t             state;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [IW-1:0]      gnt_q;
    logic [31:0]        rbuf;
    logic [NPORTS-1:0]  resp_valid_q;
    logic               busy_q;
    logic               r_enable_q;
    logic [31:0]        r_addr_q;
    logic               w_enable_q;
    logic [31:0]        w_addr_q;
    logic [31:0]        w_data_q;

    logic               gnt_found;
    logic [IW-1:0]      gnt_idx;
    logic [NPORTS-1:0]  gnt_onehot;
    logic               full_word;
    logic [31:0]        sel_addr;

    function automatic logic [NPORTS-1:0] port_onehot(input logic [IW-1:0] idx);
        logic [NPORTS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] nd, input logic [31:0] old,
                                                input logic [3:0] strb);
        logic [31:0] m;
        for (int k = 0; k < 4; k++)
            m[8*k +: 8] = strb[k] ? nd[8*k +: 8] : old[8*k +: 8];
        return m;
    endfunction

`ifdef DMEM_CTRL_RR_EN
    logic [IW-1:0] rr_ptr;
    int            rr_p;

    // Search starts at the pointer and wraps, so the last winner gets lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_p      = 0;
        for (int k = 0; k < NPORTS; k++) begin
            rr_p = int'(rr_ptr) + k;
            if (rr_p >= NPORTS) rr_p = rr_p - NPORTS;
            if (!gnt_found && bus.req_valid[rr_p]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(rr_p);
            end
        end
    end
`else
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end
`endif

    assign gnt_onehot = gnt_found ? port_onehot(gnt_idx) : '0;
    assign full_word  = bus.req_we[gnt_idx] && (bus.req_wstrb[gnt_idx] == 4'hF);
    assign sel_addr   = {bus.req_addr[gnt_idx][31:2], 2'b00};

    // Acceptance is visible in the IDLE cycle itself, so req_ready cannot wait for a register.
    assign bus.req_ready  = (state == IDLE && !rst) ? gnt_onehot : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rbuf;
    assign bus.busy       = busy_q;
    assign bus.r_enable   = r_enable_q;
    assign bus.r_addr     = r_addr_q;
    assign bus.w_enable   = w_enable_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.w_data     = w_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            gnt_q        <= '0;
            rbuf         <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            r_enable_q   <= 1'b0;
            r_addr_q     <= '0;
            w_enable_q   <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
`ifdef DMEM_CTRL_RR_EN
            rr_ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        we_q    <= bus.req_we[gnt_idx];
                        addr_q  <= sel_addr;
                        wdata_q <= bus.req_wdata[gnt_idx];
                        wstrb_q <= bus.req_wstrb[gnt_idx];
                        gnt_q   <= gnt_idx;
                        busy_q  <= 1'b1;
`ifdef DMEM_CTRL_RR_EN
                        rr_ptr  <= (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + IW'(1);
`endif
                        if (full_word) begin
                            state      <= WRITE;
                            w_enable_q <= 1'b1;
                            w_addr_q   <= sel_addr;
                            w_data_q   <= bus.req_wdata[gnt_idx];
                        end else begin
                            state      <= READ;
                            r_enable_q <= 1'b1;
                            r_addr_q   <= sel_addr;
                        end
                    end
                end
                READ: begin
                    rbuf       <= bus.r_data;
                    r_enable_q <= 1'b0;
                    r_addr_q   <= '0;
                    if (we_q) begin
                        state      <= WRITE;
                        w_enable_q <= 1'b1;
                        w_addr_q   <= addr_q;
                        w_data_q   <= merge_bytes(wdata_q, bus.r_data, wstrb_q);
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= port_onehot(gnt_q);
                    end
                end
                WRITE: begin
                    // Full-word stores never read, so they report the stored word instead.
                    if (wstrb_q == 4'hF) rbuf <= wdata_q;
                    w_enable_q   <= 1'b0;
                    w_addr_q     <= '0;
                    w_data_q     <= '0;
                    state        <= RESP;
                    resp_valid_q <= port_onehot(gnt_q);
                end
                RESP: begin
                    resp_valid_q <= '0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: transaction-level model plus directed literal checks.
module tb_dmem_ctrl;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dmem_ctrl_if #(.NPORTS(NP)) bus ();
    dmem_ctrl #(.NPORTS(NP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } rq_t;

    typedef struct packed {
        logic          r_en;
        logic [31:0]   r_addr;
        logic          w_en;
        logic [31:0]   w_addr;
        logic [31:0]   w_data;
        logic [NP-1:0] resp;
        logic [31:0]   rdata;
    } exp_t;

    rq_t         q0[$];
    rq_t         q1[$];
    logic [31:0] mem [0:255];

    function automatic logic [31:0] init_word(input int i);
        case (i)
            65:      return 32'hDEADBEEF;
            16:      return 32'h55667788;
            32:      return 32'hCAFEF00D;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle(input exp_t e, input logic [NP-1:0] rdy, input logic bsy,
                             input logic rd_chk);
        chk("req_ready", 32'(bus.req_ready), 32'(rdy));
        chk("busy", 32'(bus.busy), 32'(bsy));
        chk("r_enable", 32'(bus.r_enable), 32'(e.r_en));
        chk("r_addr", bus.r_addr, e.r_addr);
        chk("w_enable", 32'(bus.w_enable), 32'(e.w_en));
        chk("w_addr", bus.w_addr, e.w_addr);
        chk("w_data", bus.w_data, e.w_data);
        chk("resp_valid", 32'(bus.resp_valid), 32'(e.resp));
        if (rd_chk) chk("resp_rdata", bus.resp_rdata, e.rdata);
    endtask

    // dcache: combinational read, write commits at posedge
    assign bus.r_data = mem[bus.r_addr[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.w_enable && !rst) mem[bus.w_addr[9:2]] = bus.w_data;
        end
    end

    // requesters: hold valid and payload until req_ready is seen
    initial begin
        logic [NP-1:0] seen;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        forever begin
            @(negedge clk);
            seen = bus.req_ready;
            @(posedge clk);
            #1;
            if (seen[0] && q0.size() != 0) void'(q0.pop_front());
            if (seen[1] && q1.size() != 0) void'(q1.pop_front());
            bus.req_valid[0] = (q0.size() != 0);
            if (q0.size() != 0) begin
                bus.req_we[0]    = q0[0].we;
                bus.req_addr[0]  = q0[0].addr;
                bus.req_wdata[0] = q0[0].wdata;
                bus.req_wstrb[0] = q0[0].strb;
            end
            bus.req_valid[1] = (q1.size() != 0);
            if (q1.size() != 0) begin
                bus.req_we[1]    = q1[0].we;
                bus.req_addr[1]  = q1[0].addr;
                bus.req_wdata[1] = q1[0].wdata;
                bus.req_wstrb[1] = q1[0].strb;
            end
        end
    end

    // Model: on a grant, the whole expected cycle-by-cycle response is queued up front.
    initial begin
        exp_t          sched[$];
        exp_t          e;
        logic [31:0]   shadow [0:255];
        logic [NP-1:0] rdy;
        logic [31:0]   old;
        logic [31:0]   mask;
        rq_t           r;
        int            g;
        int            ptr_m;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        ptr_m = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sched.delete();
                ptr_m = 0;
                cmp_cycle('0, '0, 1'b0, 1'b1);
            end else if (sched.size() == 0) begin
                g = -1;
                for (int k = 0; k < NP; k++) begin
`ifdef DMEM_CTRL_RR_EN
                    if (g < 0 && bus.req_valid[(ptr_m + k) % NP]) g = (ptr_m + k) % NP;
`else
                    if (g < 0 && bus.req_valid[k]) g = k;
`endif
                end
                rdy = '0;
                if (g >= 0) rdy[g] = 1'b1;
                cmp_cycle('0, rdy, 1'b0, 1'b0);
                if (g >= 0) begin
                    ptr_m   = (g + 1) % NP;
                    r.we    = bus.req_we[g];
                    r.addr  = {bus.req_addr[g][31:2], 2'b00};
                    r.wdata = bus.req_wdata[g];
                    r.strb  = bus.req_wstrb[g];
                    old     = shadow[r.addr[9:2]];
                    mask    = {{8{r.strb[3]}}, {8{r.strb[2]}}, {8{r.strb[1]}}, {8{r.strb[0]}}};
                    if (r.we && r.strb == 4'hF) begin
                        e = '0; e.w_en = 1'b1; e.w_addr = r.addr; e.w_data = r.wdata;
                        sched.push_back(e);
                        e = '0; e.resp = rdy; e.rdata = r.wdata;
                        sched.push_back(e);
                    end else begin
                        e = '0; e.r_en = 1'b1; e.r_addr = r.addr;
                        sched.push_back(e);
                        if (r.we) begin
                            e = '0; e.w_en = 1'b1; e.w_addr = r.addr;
                            e.w_data = (r.wdata & mask) | (old & ~mask);
                            sched.push_back(e);
                        end
                        e = '0; e.resp = rdy; e.rdata = old;
                        sched.push_back(e);
                    end
                end
            end else begin
                e = sched.pop_front();
                cmp_cycle(e, '0, 1'b1, e.resp != '0);
                if (e.w_en) shadow[e.w_addr[9:2]] = e.w_data;
            end
        end
    end

    task automatic push_req(input int p, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        rq_t r;
        r.we = we; r.addr = a; r.wdata = d; r.strb = s;
        if (p == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic wait_ready(input int p, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready[p]) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'h1);
    endtask

    initial begin
        logic [NP-1:0] grants[$];
        int            gcyc[$];
        logic [NP-1:0] exp_g;
        int            cyc;
        int            act;

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset resp_rdata", bus.resp_rdata, 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);

        // load, port 0
        push_req(0, 1'b0, 32'h104, 32'h0, 4'h0);
        wait_ready(0, "t1 ready");
        @(negedge clk);
        chk("t1 r_enable", 32'(bus.r_enable), 32'h1);
        chk("t1 r_addr", bus.r_addr, 32'h104);
        @(negedge clk);
        chk("t1 resp_valid", 32'(bus.resp_valid), 32'h1);
        chk("t1 rdata", bus.resp_rdata, 32'hDEADBEEF);

        // full store, port 1
        push_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        wait_ready(1, "t2 ready");
        @(negedge clk);
        chk("t2 r_enable", 32'(bus.r_enable), 32'h0);
        chk("t2 w_enable", 32'(bus.w_enable), 32'h1);
        chk("t2 w_addr", bus.w_addr, 32'h20);
        chk("t2 w_data", bus.w_data, 32'h12345678);
        @(negedge clk);
        chk("t2 r_enable2", 32'(bus.r_enable), 32'h0);
        chk("t2 resp_valid", 32'(bus.resp_valid), 32'h2);

        // byte store into lane 1
        push_req(0, 1'b1, 32'h20, 32'h0000AB00, 4'b0010);
        wait_ready(0, "t3 ready");
        @(negedge clk);
        chk("t3 r_enable", 32'(bus.r_enable), 32'h1);
        @(negedge clk);
        chk("t3 w_enable", 32'(bus.w_enable), 32'h1);
        chk("t3 w_data", bus.w_data, 32'h1234AB78);
        @(negedge clk);
        chk("t3 resp_valid", 32'(bus.resp_valid), 32'h1);
        chk("t3 rdata", bus.resp_rdata, 32'h12345678);

        // unaligned load address is word-aligned
        push_req(1, 1'b0, 32'h22, 32'h0, 4'h0);
        wait_ready(1, "t3b ready");
        @(negedge clk);
        chk("t3b r_addr", bus.r_addr, 32'h20);
        @(negedge clk);
        chk("t3b rdata", bus.resp_rdata, 32'h1234AB78);

        // wstrb = 0 writes the word back unchanged
        push_req(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'h0);
        wait_ready(0, "t6 ready");
        @(negedge clk);
        chk("t6 r_enable", 32'(bus.r_enable), 32'h1);
        @(negedge clk);
        chk("t6 w_enable", 32'(bus.w_enable), 32'h1);
        chk("t6 w_data", bus.w_data, 32'hCAFEF00D);
        @(negedge clk);
        chk("t6 resp_valid", 32'(bus.resp_valid), 32'h1);
        chk("t6 rdata", bus.resp_rdata, 32'hCAFEF00D);
        push_req(1, 1'b0, 32'h80, 32'h0, 4'h0);
        wait_ready(1, "t6 readback ready");
        repeat (2) @(negedge clk);
        chk("t6 readback", bus.resp_rdata, 32'hCAFEF00D);

        // reset during READ of a byte store aborts it
        push_req(0, 1'b1, 32'h40, 32'h000000FF, 4'b0001);
        wait_ready(0, "t5 ready");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t5 r_enable", 32'(bus.r_enable), 32'h0);
        chk("t5 busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        act = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.w_enable || bus.resp_valid != '0) act++;
        end
        chk("t5 no write or resp", 32'(act), 32'h0);
        chk("t5 mem unchanged", mem[16], 32'h55667788);
        push_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
        wait_ready(1, "t5 readback ready");
        repeat (2) @(negedge clk);
        chk("t5 readback", bus.resp_rdata, 32'h55667788);

        // both ports hold valid; fresh reset restarts the round-robin pointer
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_req(0, 1'b0, 32'h104, 32'h0, 4'h0);
            push_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        end
        cyc = 0;
        while (grants.size() < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready != '0) begin
                grants.push_back(bus.req_ready);
                gcyc.push_back(cyc);
            end
        end
        chk("t4 grant count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < grants.size(); i++) begin
`ifdef DMEM_CTRL_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = (i < 3) ? 2'b01 : 2'b10;
`endif
            chk($sformatf("t4 grant%0d", i), 32'(grants[i]), 32'(exp_g));
            if (i > 0) chk($sformatf("t4 spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
